video_sig_gen: RTL and testbench

Free-running raster timing generator for the 1280x720@60 HDMI output path. It produces the hcount/vcount coordinates consumed by the sprite and palette-lookup stages, plus hsync/vsync/active-draw, a new-frame strobe and a frame counter. It also supplies copies of the sync/active signals delayed by the pixel-pipeline latency, so they arrive at the TMDS encoders aligned with the RGB data.

---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/sync_delay_pipe.sv | 31 +++
 rtl/video_sig_gen.sv | 131 +++++++++++++
 tb/tb_video_sig_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Purpose  : 1280x720@60 raster timing constants shared by the video stages.
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  localparam int H_ACTIVE   = 1280;
  localparam int H_FP       = 110;
  localparam int H_SYNC     = 40;
  localparam int H_BP       = 220;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE   = 720;
  localparam int V_FP       = 5;
  localparam int V_SYNC     = 5;
  localparam int V_BP       = 20;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: [START, END)
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam int FPS        = 60;
  localparam int SYNC_DELAY = 4;

  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } sync_flags_t;

endpackage
`default_nettype wire

// File: rtl/sync_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sync_delay_pipe
// Purpose  : DEPTH x WIDTH shift register with synchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module sync_delay_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_sig_gen
// Purpose  : Free-running raster timing generator with pipeline-aligned syncs.
// Revision : 1.0 - initial release
// ============================================================================
module video_sig_gen #(
  parameter int H_ACTIVE   = video_timing_pkg::H_ACTIVE,
  parameter int H_FP       = video_timing_pkg::H_FP,
  parameter int H_SYNC     = video_timing_pkg::H_SYNC,
  parameter int H_BP       = video_timing_pkg::H_BP,
  parameter int V_ACTIVE   = video_timing_pkg::V_ACTIVE,
  parameter int V_FP       = video_timing_pkg::V_FP,
  parameter int V_SYNC     = video_timing_pkg::V_SYNC,
  parameter int V_BP       = video_timing_pkg::V_BP,
  parameter int FPS        = video_timing_pkg::FPS,
  parameter int SYNC_DELAY = video_timing_pkg::SYNC_DELAY
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out,
  output logic        hs_dly_out,
  output logic        vs_dly_out,
  output logic        ad_dly_out
);

  import video_timing_pkg::*;

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] C_H_LAST   = 12'(C_H_TOTAL - 1);
  localparam logic [11:0] C_V_LAST   = 12'(C_V_TOTAL - 1);
  localparam logic [11:0] C_H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] C_V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] C_HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] C_VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] C_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0]  C_FC_LAST  = 6'(FPS - 1);

  if (C_H_TOTAL > 2048) begin : g_chk_h_total
    $fatal(1, "video_sig_gen: H_TOTAL exceeds 2048");
  end
  if (C_V_TOTAL > 1024) begin : g_chk_v_total
    $fatal(1, "video_sig_gen: V_TOTAL exceeds 1024");
  end
  if (FPS < 1 || FPS > 64) begin : g_chk_fps
    $fatal(1, "video_sig_gen: FPS must be 1..64");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 15) begin : g_chk_delay
    $fatal(1, "video_sig_gen: SYNC_DELAY must be 1..15");
  end

  logic [10:0] r_hcount, w_hcount_next;
  logic [9:0]  r_vcount, w_vcount_next;
  logic [11:0] w_h12, w_v12;
  logic        r_hs, r_vs, r_ad, r_nf;
  logic        w_hs_next, w_vs_next, w_ad_next, w_nf_next;
  logic [5:0]  r_fc, w_fc_next;

  // Flags are derived from the next counter values so they line up with them
  always_comb begin
    w_hcount_next = r_hcount + 11'd1;
    w_vcount_next = r_vcount;
    if ({1'b0, r_hcount} == C_H_LAST) begin
      w_hcount_next = '0;
      w_vcount_next = ({2'b00, r_vcount} == C_V_LAST) ? '0 : r_vcount + 10'd1;
    end
    w_h12     = {1'b0, w_hcount_next};
    w_v12     = {2'b00, w_vcount_next};
    w_ad_next = (w_h12 < C_H_ACT) && (w_v12 < C_V_ACT);
    w_hs_next = (w_h12 >= C_HS_START) && (w_h12 < C_HS_END);
    w_vs_next = (w_v12 >= C_VS_START) && (w_v12 < C_VS_END);
    w_nf_next = (w_h12 == C_H_ACT) && (w_v12 == C_V_ACT);
    w_fc_next = r_fc;
    if (w_nf_next) w_fc_next = (r_fc == C_FC_LAST) ? '0 : r_fc + 6'd1;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_ad     <= 1'b0;
      r_nf     <= 1'b0;
      r_fc     <= '0;
    end else begin
      r_hcount <= w_hcount_next;
      r_vcount <= w_vcount_next;
      r_hs     <= w_hs_next;
      r_vs     <= w_vs_next;
      r_ad     <= w_ad_next;
      r_nf     <= w_nf_next;
      r_fc     <= w_fc_next;
    end
  end

  sync_flags_t w_flags, w_flags_dly;
  assign w_flags = '{hs: r_hs, vs: r_vs, ad: r_ad};

  sync_delay_pipe #(
    .DEPTH (SYNC_DELAY),
    .WIDTH ($bits(sync_flags_t))
  ) u_sync_delay_pipe (
    .clk    (pixel_clk_in),
    .rst_n  (rst_in),
    .i_data (w_flags),
    .o_data (w_flags_dly)
  );

  assign hcount_out = r_hcount;
  assign vcount_out = r_vcount;
  assign hs_out     = r_hs;
  assign vs_out     = r_vs;
  assign ad_out     = r_ad;
  assign nf_out     = r_nf;
  assign fc_out     = r_fc;
  assign hs_dly_out = w_flags_dly.hs;
  assign vs_dly_out = w_flags_dly.vs;
  assign ad_dly_out = w_flags_dly.ad;

endmodule
`default_nettype wire

// File: tb/tb_video_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_sig_gen
// Purpose  : Self-checking bench: shrunken raster (two delays) plus 720p line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_sig_gen;

  // Shrunken raster: 28 x 12, hs at h 19..22, vs at v 8..9, nf at (16,6)
  localparam int HA = 16, HF = 3, HS = 4, HB = 5, HT = 28;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2, VT = 12;
  localparam int NFPS = 60;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] h4, h1, hd;
  logic [9:0]  v4, v1, vd;
  logic        hs4, vs4, ad4, nf4, hsd4, vsd4, add4;
  logic        hs1, vs1, ad1, nf1, hsd1, vsd1, add1;
  logic        hsx, vsx, adx, nfx, hsdx, vsdx, addx;
  logic [5:0]  fc4, fc1, fcx;

  video_sig_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .FPS(NFPS), .SYNC_DELAY(4)) u_dut4 (
    .pixel_clk_in(clk), .rst_in(rst_n), .hcount_out(h4), .vcount_out(v4),
    .hs_out(hs4), .vs_out(vs4), .ad_out(ad4), .nf_out(nf4), .fc_out(fc4),
    .hs_dly_out(hsd4), .vs_dly_out(vsd4), .ad_dly_out(add4));

  video_sig_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .FPS(NFPS), .SYNC_DELAY(1)) u_dut1 (
    .pixel_clk_in(clk), .rst_in(rst_n), .hcount_out(h1), .vcount_out(v1),
    .hs_out(hs1), .vs_out(vs1), .ad_out(ad1), .nf_out(nf1), .fc_out(fc1),
    .hs_dly_out(hsd1), .vs_dly_out(vsd1), .ad_dly_out(add1));

  video_sig_gen u_dut720 (
    .pixel_clk_in(clk), .rst_in(rst_n), .hcount_out(hd), .vcount_out(vd),
    .hs_out(hsx), .vs_out(vsx), .ad_out(adx), .nf_out(nfx), .fc_out(fcx),
    .hs_dly_out(hsdx), .vs_dly_out(vsdx), .ad_dly_out(addx));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] flags(input int h, input int v, input int ha, input int hss,
                                       input int hse, input int va, input int vss, input int vse);
    return {(h >= hss && h < hse), (v >= vss && v < vse), (h < ha && v < va)};
  endfunction

  // Model state: small raster, its flag history (hist[k] = flags k cycles ago), 720p position
  int mh = 0, mv = 0, mfc = 0, dh = 0, dv = 0;
  logic mnf = 1'b0;
  logic [2:0] hist [16];
  logic [2:0] dflg;

  task automatic step(input logic rst_val);
    rst_n = rst_val;
    @(posedge clk);
    #1;
    if (!rst_val) begin
      mh = 0; mv = 0; mfc = 0; dh = 0; dv = 0; mnf = 1'b0; dflg = 3'b000;
      for (int k = 0; k < 16; k++) hist[k] = 3'b000;
    end else begin
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      mh = (mh == HT - 1) ? 0 : mh + 1;
      if (mh == 0) mv = (mv == VT - 1) ? 0 : mv + 1;
      hist[0] = flags(mh, mv, HA, 19, 23, VA, 8, 10);
      mnf = (mh == 16 && mv == 6);
      if (mnf) mfc = (mfc == NFPS - 1) ? 0 : mfc + 1;
      dh = (dh == 1649) ? 0 : dh + 1;
      if (dh == 0) dv = (dv == 749) ? 0 : dv + 1;
      dflg = flags(dh, dv, 1280, 1390, 1430, 720, 725, 730);
    end
    check("s4_hcount", h4, mh);
    check("s4_vcount", v4, mv);
    check("s4_flags", {hs4, vs4, ad4}, hist[0]);
    check("s4_nf", nf4, mnf);
    check("s4_fc", fc4, mfc);
    check("s4_dly", {hsd4, vsd4, add4}, hist[4]);
    check("s1_pos", {h1, 5'd0, v1}, {mh[10:0], 5'd0, mv[9:0]});
    check("s1_flags", {hs1, vs1, ad1, nf1}, {hist[0], mnf});
    check("s1_dly", {hsd1, vsd1, add1}, hist[1]);
    check("hd_hcount", hd, dh);
    check("hd_vcount", vd, dv);
    check("hd_flags", {hsx, vsx, adx}, dflg);
    check("hd_nf", nfx, 1'b0);
  endtask

  initial begin
    int hs_cnt, nf_cnt, last_nf, cyc;
    logic saw_wrap, found;

    // Reset held 5 cycles: everything reads zero
    for (int i = 0; i < 5; i++) step(1'b0);
    check("rst_fc", fc4, 0);
    check("rst_dly", {hsd4, vsd4, add4, hsdx, vsdx, addx}, 0);

    // First edge out of reset presents (1,0), inside active area
    step(1'b1);
    check("first_h", h4, 1);
    check("first_hd", hd, 1);
    check("first_flags", {hsx, vsx, adx}, 3'b001);

    // One 720p line: hs is exactly 40 cycles wide, ad drops at 1280
    hs_cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b1);
      if (hsx) hs_cnt++;
      if (hd == 1280) check("hd_ad_fall", adx, 1'b0);
      if (hd == 1279 && vd == 0) check("hd_ad_last", adx, 1'b1);
      if (hd == 1390) check("hd_hs_rise", hsx, 1'b1);
      if (hd == 1430) check("hd_hs_fall", hsx, 1'b0);
      if (hd == 0) check("hd_wrap_v", vd, 1);
    end
    check("hd_hs_width", hs_cnt, 40);

    // 60+ small frames: nf period, fc wrap coincident with nf
    nf_cnt = 0; last_nf = -1; cyc = 0; saw_wrap = 1'b0;
    for (int i = 0; i < 61 * FRAME + 100; i++) begin
      step(1'b1);
      cyc++;
      if (nf4) begin
        nf_cnt++;
        check("nf_pos", {h4, 5'd0, v4}, {11'd16, 5'd0, 10'd6});
        if (last_nf >= 0) check("nf_period", cyc - last_nf, FRAME);
        last_nf = cyc;
        if (fc4 == 0) saw_wrap = 1'b1;
      end
    end
    check("nf_count_ge60", (nf_cnt >= 60), 1'b1);
    check("fc_wrap_seen", saw_wrap, 1'b1);

    // Mid-frame reset at (10,3), bounded search
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(1'b1);
      if (h4 == 10 && v4 == 3) found = 1'b1;
    end
    check("mid_found", found, 1'b1);
    step(1'b0);
    check("mid_rst_all", {h4, v4, hs4, vs4, ad4, nf4, fc4, hsd4, vsd4, add4}, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      check("mid_resume_h", h4, i);
      if (i <= 3) check("mid_dly_zero", {hsd4, vsd4, add4}, 3'b000);
      if (i >= 5) check("mid_dly_ad", add4, 1'b1);
    end
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
